// File: rtl/sd_access_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_access_sched_pkg
//  Description : Shared definitions for the SD access scheduler (the sd_defs
//                set): FSM state encodings, default gap/timeout parameters,
//                statistics counter widths and a small state-decode helper.
//  Revision    : 1.0  - initial release
// ============================================================================
package sd_access_sched_pkg;

    // Scheduler FSM states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        S_INIT = 3'd0,  // card initialisation owns the pins
        S_IDLE = 3'd1,  // bus quiet, sampling front-end requests
        S_WR   = 3'd2,  // write engine granted
        S_RD   = 3'd3,  // read engine granted
        S_GAP  = 3'd4   // enforced idle gap between operations
    } sched_state_t;

    // Default configuration values
    localparam int c_GAP_CLKS_DEF = 8;
    localparam int c_TO_CLKS_DEF  = 65535;
    localparam int c_TO_W_DEF     = 16;

    // Statistics counter widths (optional feature)
    localparam int c_OP_STAT_W    = 16;
    localparam int c_TO_STAT_W    = 8;

    // True while an engine holds the grant
    function automatic logic sched_is_grant(input sched_state_t st);
        return (st == S_WR) || (st == S_RD);
    endfunction

endpackage : sd_access_sched_pkg
`default_nettype wire

// File: rtl/sd_access_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sd_access_sched_rr_pick
//  Description : 2-way round-robin picker (sd_rr_pick). Combinational.
//                req[0] = write request, req[1] = read request.
//                When both request, the side that did NOT win last is picked:
//                last=1 (last served was a write) -> read, last=0 -> write.
//                grant is one-hot, or zero when nothing is requested.
//  Ports       : req[1:0] in, last in, grant[1:0] out
//  Revision    : 1.0  - initial release
// ============================================================================
module sd_access_sched_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b10 : 2'b01;
        end
    end

endmodule : sd_access_sched_rr_pick
`default_nettype wire

// File: rtl/sd_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sd_access_sched
//  Description : Shares the single SPI-mode SD card port among the init,
//                block-write and block-read engines. Traffic is held off until
//                init completes; afterwards one engine at a time is granted
//                with a level start/ok handshake. The granted engine's MOSI/CSn
//                is muxed to the pins; an idle gap (CSn=1, MOSI=1) separates
//                operations and each operation is bounded by a timeout.
//                All state updates occur on the falling edge of SD_CK.
//
//  Parameters  : GAP_CLKS - SD_CK cycles of idle gap between ops (>=1)
//                TO_CLKS  - op timeout in SD_CK cycles from start (>=16)
//                TO_W     - timeout counter width (must hold TO_CLKS)
//
//  Ports       : SD_CK, rst_n (async, active-low)
//                init_o/init_mosi/init_csn      - init engine
//                wr_req, rd_req                 - front-end requests (level)
//                wr_start/wr_mosi/wr_csn/wr_ok  - write engine handshake
//                rd_start/rd_mosi/rd_csn/rd_ok  - read engine handshake
//                SD_MOSI, SD_CSn                - card pins
//                busy                           - FSM not in S_IDLE
//                wr_done, rd_done, err          - 1-cycle completion pulses
//
//  Options     : SD_SCHED_STATS_EN - when defined, adds saturating counters
//                wr_cnt[15:0], rd_cnt[15:0], to_cnt[7:0] counting wr_done,
//                rd_done and err pulses; cleared only by rst_n.
//
//  Revision    : 1.0  - initial release
// ============================================================================
module sd_access_sched
    import sd_access_sched_pkg::*;
#(
    parameter int GAP_CLKS = c_GAP_CLKS_DEF,
    parameter int TO_CLKS  = c_TO_CLKS_DEF,
    parameter int TO_W     = c_TO_W_DEF
) (
    input  logic SD_CK,
    input  logic rst_n,
    // init engine
    input  logic init_o,
    input  logic init_mosi,
    input  logic init_csn,
    // front-end requests
    input  logic wr_req,
    input  logic rd_req,
    // write engine
    output logic wr_start,
    input  logic wr_mosi,
    input  logic wr_csn,
    input  logic wr_ok,
    // read engine
    output logic rd_start,
    input  logic rd_mosi,
    input  logic rd_csn,
    input  logic rd_ok,
    // card pins
    output logic SD_MOSI,
    output logic SD_CSn,
    // status
    output logic busy,
    output logic wr_done,
    output logic rd_done,
    output logic err
`ifdef SD_SCHED_STATS_EN
    ,
    output logic [c_OP_STAT_W-1:0] wr_cnt,
    output logic [c_OP_STAT_W-1:0] rd_cnt,
    output logic [c_TO_STAT_W-1:0] to_cnt
`endif
);

    localparam int                    c_GAP_W    = $clog2(GAP_CLKS + 1);
    localparam logic [c_GAP_W-1:0]    c_GAP_LOAD = c_GAP_W'(GAP_CLKS);
    localparam logic [TO_W-1:0]       c_TO_LOAD  = TO_W'(TO_CLKS);

    sched_state_t        r_state;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_last_wr;
    logic                r_wr_start;
    logic                r_rd_start;
    logic                r_wr_done;
    logic                r_rd_done;
    logic                r_err;

    logic [1:0]          w_grant;
    logic                w_to_expire;
    logic                w_mosi;
    logic                w_csn;

    // ------------------------------------------------------------------------
    // Round-robin arbitration between the two front-end requests
    // ------------------------------------------------------------------------
    sd_access_sched_rr_pick u_rr_pick (
        .req   ({rd_req, wr_req}),
        .last  (r_last_wr),
        .grant (w_grant)
    );

    // The counter is loaded with TO_CLKS on the grant edge and decremented on
    // every following edge; the edge that would take it from 1 to 0 is the
    // TO_CLKS-th edge after start rose, which is where the timeout fires.
    assign w_to_expire = (r_to_cnt <= TO_W'(1));

    // ------------------------------------------------------------------------
    // Scheduler FSM with registered handshake and pulse outputs
    // ------------------------------------------------------------------------
    always_ff @(negedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
            r_last_wr  <= 1'b0;
            r_wr_start <= 1'b0;
            r_rd_start <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_err     <= 1'b0;

            if ((r_state != S_INIT) && !init_o) begin
                // Card re-initialisation: drop any grant immediately. An
                // aborted operation is reported as an error.
                r_state    <= S_INIT;
                r_wr_start <= 1'b0;
                r_rd_start <= 1'b0;
                r_err      <= sched_is_grant(r_state);
            end else begin
                case (r_state)
                    S_INIT: begin
                        if (init_o) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= c_GAP_LOAD;
                        end
                    end

                    S_IDLE: begin
                        if (w_grant[0]) begin
                            r_state    <= S_WR;
                            r_wr_start <= 1'b1;
                            r_to_cnt   <= c_TO_LOAD;
                        end else if (w_grant[1]) begin
                            r_state    <= S_RD;
                            r_rd_start <= 1'b1;
                            r_to_cnt   <= c_TO_LOAD;
                        end
                    end

                    S_WR: begin
                        // ok is checked first so a completion on the expiry
                        // edge is reported as success.
                        if (wr_ok) begin
                            r_state    <= S_GAP;
                            r_wr_start <= 1'b0;
                            r_wr_done  <= 1'b1;
                            r_last_wr  <= 1'b1;
                            r_gap_cnt  <= c_GAP_LOAD;
                        end else if (w_to_expire) begin
                            r_state    <= S_GAP;
                            r_wr_start <= 1'b0;
                            r_err      <= 1'b1;
                            r_gap_cnt  <= c_GAP_LOAD;
                        end else begin
                            r_to_cnt   <= r_to_cnt - TO_W'(1);
                        end
                    end

                    S_RD: begin
                        if (rd_ok) begin
                            r_state    <= S_GAP;
                            r_rd_start <= 1'b0;
                            r_rd_done  <= 1'b1;
                            r_last_wr  <= 1'b0;
                            r_gap_cnt  <= c_GAP_LOAD;
                        end else if (w_to_expire) begin
                            r_state    <= S_GAP;
                            r_rd_start <= 1'b0;
                            r_err      <= 1'b1;
                            r_gap_cnt  <= c_GAP_LOAD;
                        end else begin
                            r_to_cnt   <= r_to_cnt - TO_W'(1);
                        end
                    end

                    S_GAP: begin
                        // Besides the gap time, wait until both engines have
                        // released ok, so a stale ok cannot complete the next
                        // grant on its first cycle.
                        if (r_gap_cnt != '0) begin
                            r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                        end else if (!wr_ok && !rd_ok) begin
                            r_state   <= S_IDLE;
                        end
                    end

                    default: begin
                        r_state    <= S_INIT;
                        r_wr_start <= 1'b0;
                        r_rd_start <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pin mux: the owner of the bus drives the pins, otherwise the bus idles
    // high (deselected card, MOSI high).
    // ------------------------------------------------------------------------
    always_comb begin
        w_mosi = 1'b1;
        w_csn  = 1'b1;
        case (r_state)
            S_INIT: begin
                w_mosi = init_mosi;
                w_csn  = init_csn;
            end
            S_WR: begin
                w_mosi = wr_mosi;
                w_csn  = wr_csn;
            end
            S_RD: begin
                w_mosi = rd_mosi;
                w_csn  = rd_csn;
            end
            default: begin
                w_mosi = 1'b1;
                w_csn  = 1'b1;
            end
        endcase
    end

    assign SD_MOSI  = w_mosi;
    assign SD_CSn   = w_csn;
    assign busy     = (r_state != S_IDLE);
    assign wr_start = r_wr_start;
    assign rd_start = r_rd_start;
    assign wr_done  = r_wr_done;
    assign rd_done  = r_rd_done;
    assign err      = r_err;

`ifdef SD_SCHED_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating operation statistics, counted from the registered pulses
    // ------------------------------------------------------------------------
    logic [c_OP_STAT_W-1:0] r_wr_cnt;
    logic [c_OP_STAT_W-1:0] r_rd_cnt;
    logic [c_TO_STAT_W-1:0] r_to_stat;

    always_ff @(negedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_to_stat <= '0;
        end else begin
            if (r_wr_done && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + c_OP_STAT_W'(1);
            end
            if (r_rd_done && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + c_OP_STAT_W'(1);
            end
            if (r_err && (r_to_stat != '1)) begin
                r_to_stat <= r_to_stat + c_TO_STAT_W'(1);
            end
        end
    end

    assign wr_cnt = r_wr_cnt;
    assign rd_cnt = r_rd_cnt;
    assign to_cnt = r_to_stat;
`endif

endmodule : sd_access_sched
`default_nettype wire

// File: tb/tb_sd_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_access_sched
//  Description : Self-checking bench for sd_access_sched. Pin-mux behaviour is
//                checked from stimulus tables; arbitration, gap, timeout,
//                ok-vs-timeout priority and re-init abort are checked with
//                hand-written sequences. Statistics checks are compiled in
//                when SD_SCHED_STATS_EN is defined.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_sd_access_sched;

    localparam int GAP = 8;
    localparam int TO  = 100;

    logic SD_CK = 1'b0;
    logic rst_n;
    logic init_o, init_mosi, init_csn;
    logic wr_req, rd_req;
    logic wr_start, wr_mosi, wr_csn, wr_ok;
    logic rd_start, rd_mosi, rd_csn, rd_ok;
    logic SD_MOSI, SD_CSn, busy, wr_done, rd_done, err;
`ifdef SD_SCHED_STATS_EN
    logic [15:0] wr_cnt, rd_cnt;
    logic [7:0]  to_cnt;
`endif

    sd_access_sched #(
        .GAP_CLKS (GAP),
        .TO_CLKS  (TO),
        .TO_W     (16)
    ) dut (
        .SD_CK     (SD_CK),
        .rst_n     (rst_n),
        .init_o    (init_o),
        .init_mosi (init_mosi),
        .init_csn  (init_csn),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .wr_start  (wr_start),
        .wr_mosi   (wr_mosi),
        .wr_csn    (wr_csn),
        .wr_ok     (wr_ok),
        .rd_start  (rd_start),
        .rd_mosi   (rd_mosi),
        .rd_csn    (rd_csn),
        .rd_ok     (rd_ok),
        .SD_MOSI   (SD_MOSI),
        .SD_CSn    (SD_CSn),
        .busy      (busy),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
        .err       (err)
`ifdef SD_SCHED_STATS_EN
        ,
        .wr_cnt    (wr_cnt),
        .rd_cnt    (rd_cnt),
        .to_cnt    (to_cnt)
`endif
    );

    always #5 SD_CK = ~SD_CK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic im, ic, wm, wc, rm, rc;  // init/wr/rd engine mosi, csn
        logic em, ec;                  // expected SD_MOSI, SD_CSn
    } mux_vec_t;

    mux_vec_t tv_init [4];
    mux_vec_t tv_wr   [4];
    mux_vec_t tv_rd   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs settle after the falling edge; sample and drive just after the
    // rising edge, half a period away from the active edge.
    task automatic tick();
        @(posedge SD_CK);
        #1;
    endtask

    task automatic apply_mux(input mux_vec_t v, input string nm);
        init_mosi = v.im; init_csn = v.ic;
        wr_mosi   = v.wm; wr_csn   = v.wc;
        rd_mosi   = v.rm; rd_csn   = v.rc;
        #1;
        chk({nm, "_mosi"}, SD_MOSI, v.em);
        chk({nm, "_csn"},  SD_CSn,  v.ec);
    endtask

    // One complete operation: request, wait for start, optionally answer ok
    // after dly clocks (dly<0: never), wait for completion, release, idle.
    task automatic run_op(input bit is_rd, input int dly, output bit got_done, output bit got_err);
        int k;
        got_done = 1'b0;
        got_err  = 1'b0;
        if (is_rd) rd_req = 1'b1; else wr_req = 1'b1;
        k = 0;
        while (!(is_rd ? rd_start : wr_start) && k < 200) begin tick(); k++; end
        chk("op_start", is_rd ? rd_start : wr_start, 1);
        if (dly >= 0) begin
            repeat (dly) tick();
            if (is_rd) rd_ok = 1'b1; else wr_ok = 1'b1;
        end
        k = 0;
        while (!(wr_done || rd_done || err) && k < TO + 20) begin tick(); k++; end
        got_done = is_rd ? rd_done : wr_done;
        got_err  = err;
        wr_req = 1'b0; rd_req = 1'b0; wr_ok = 1'b0; rd_ok = 1'b0;
        k = 0;
        while (busy && k < 50) begin tick(); k++; end
        chk("op_back_to_idle", busy, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, gap;
        bit  flag, csn_ok, d, e;

        // inputs: im ic wm wc rm rc -> expected mosi csn
        tv_init[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tv_init[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv_init[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tv_init[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tv_wr[0]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tv_wr[1]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv_wr[2]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv_wr[3]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tv_rd[0]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv_rd[1]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv_rd[2]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tv_rd[3]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        init_o = 1'b0; init_mosi = 1'b1; init_csn = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_mosi = 1'b1; wr_csn = 1'b1; wr_ok = 1'b0;
        rd_mosi = 1'b1; rd_csn = 1'b1; rd_ok = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_wr_start", wr_start, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_wr_done",  wr_done,  0);
        chk("rst_rd_done",  rd_done,  0);
        chk("rst_err",      err,      0);
        chk("rst_busy",     busy,     1);
        rst_n = 1'b1;
        tick();

        // ---------------- init owns pins, requests held off ----------------
        for (int i = 0; i < 4; i++) begin
            apply_mux(tv_init[i], "init_mux");
            tick();
        end
        wr_req = 1'b1;
        flag = 1'b1;
        repeat (6) begin
            tick();
            if (wr_start) flag = 1'b0;
        end
        chk("init_holds_wr_start", flag, 1);

        init_mosi = 1'b0; init_csn = 1'b0;
        init_o = 1'b1;
        gap = 0; csn_ok = 1'b1;
        for (int i = 0; i < 40 && !wr_start; i++) begin
            tick();
            if (!wr_start) begin
                gap++;
                if (!SD_CSn || !SD_MOSI) csn_ok = 1'b0;
            end
        end
        chk("post_init_wr_start", wr_start, 1);
        chk("post_init_gap_pins_high", csn_ok, 1);
        chk("post_init_gap_len_in_range", (gap >= GAP) && (gap <= GAP + 2), 1);

        // ---------------- plain write, ok after 60 clocks ----------------
        for (int i = 0; i < 4; i++) begin
            apply_mux(tv_wr[i], "wr_mux");
            tick();
        end
        flag = 1'b1;
        for (int i = 4; i < 60; i++) begin
            if (!wr_start || err || wr_done) flag = 1'b0;
            tick();
        end
        chk("wr_start_held", flag, 1);
        wr_ok = 1'b1;
        tick();
        chk("wr_done_pulse", wr_done,  1);
        chk("wr_start_drop", wr_start, 0);
        chk("wr_no_err",     err,      0);
        chk("wr_busy_gap",   busy,     1);
        chk("wr_gap_csn",    SD_CSn,   1);
        wr_ok = 1'b0; wr_req = 1'b0;
        tick();
        chk("wr_done_one_cycle", wr_done, 0);
        k = 0; csn_ok = 1'b1;
        while (busy && k < 40) begin
            tick(); k++;
            if (!SD_CSn || !SD_MOSI) csn_ok = 1'b0;
        end
        chk("wr_idle_after_gap", busy, 0);
        chk("wr_gap_pins_high", csn_ok, 1);
        chk("wr_gap_len", k >= GAP - 1, 1);

        // ---------------- timeout on a write ----------------
        wr_req = 1'b1;
        k = 0;
        while (!wr_start && k < 30) begin tick(); k++; end
        chk("to_wr_start", wr_start, 1);
        k = 0; flag = 1'b0;
        while (!err && k < 150) begin
            tick(); k++;
            if (wr_done) flag = 1'b1;
        end
        chk("to_latency", k, TO);
        chk("to_start_drop", wr_start, 0);
        chk("to_no_done", flag, 0);
        wr_req = 1'b0;
        tick();
        chk("to_err_one_cycle", err, 0);

        // next request served normally
        run_op(1'b1, 5, d, e);
        chk("after_to_rd_done", d, 1);
        chk("after_to_rd_no_err", e, 0);

        // ---------------- ok on the expiry edge: ok wins ----------------
        wr_req = 1'b1;
        k = 0;
        while (!wr_start && k < 30) begin tick(); k++; end
        chk("edge_wr_start", wr_start, 1);
        repeat (TO - 1) tick();
        wr_ok = 1'b1;
        tick();
        chk("edge_done", wr_done, 1);
        chk("edge_no_err", err, 0);
        chk("edge_start_drop", wr_start, 0);
        wr_ok = 1'b0; wr_req = 1'b0;
        tick();
        chk("edge_no_late_err", err, 0);
        k = 0;
        while (busy && k < 40) begin tick(); k++; end
        chk("edge_idle", busy, 0);

        // ---------------- re-init abort during a read ----------------
        rd_req = 1'b1;
        k = 0;
        while (!rd_start && k < 30) begin tick(); k++; end
        chk("abort_rd_start", rd_start, 1);
        for (int i = 0; i < 4; i++) begin
            apply_mux(tv_rd[i], "rd_mux");
            tick();
        end
        init_mosi = 1'b0; init_csn = 1'b0;
        init_o = 1'b0;
        tick();
        chk("abort_rd_start_drop", rd_start, 0);
        chk("abort_err_pulse", err, 1);
        chk("abort_no_done", rd_done, 0);
        chk("abort_busy", busy, 1);
        chk("abort_pins_init_csn", SD_CSn, 0);
        chk("abort_pins_init_mosi", SD_MOSI, 0);
        rd_req = 1'b0;
        tick();
        chk("abort_err_one_cycle", err, 0);
        chk("abort_stays_init", SD_CSn, 0);

        // ---------------- round-robin after a fresh reset ----------------
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        init_csn = 1'b1; init_mosi = 1'b1;
        tick();
        init_o = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            gap = 0; csn_ok = 1'b1;
            k = 0;
            while (!(wr_start || rd_start) && k < 60) begin
                tick(); k++;
                if (!(wr_start || rd_start)) begin
                    gap++;
                    if (!SD_CSn) csn_ok = 1'b0;
                end
            end
            chk("rr_grant", {rd_start, wr_start}, (g % 2 == 1) ? 2'b10 : 2'b01);
            chk("rr_gap_len", gap >= GAP, 1);
            chk("rr_gap_csn", csn_ok, 1);
            repeat (3) tick();
            if (rd_start) rd_ok = 1'b1; else wr_ok = 1'b1;
            tick();
            chk("rr_done", (g % 2 == 1) ? rd_done : wr_done, 1);
            wr_ok = 1'b0; rd_ok = 1'b0;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        k = 0;
        while (busy && k < 40) begin tick(); k++; end
        chk("rr_idle", busy, 0);

`ifdef SD_SCHED_STATS_EN
        // ---------------- statistics (since last reset: 2 wr, 2 rd) --------
        run_op(1'b0, 3, d, e);
        chk("stat_wr3_done", d, 1);
        run_op(1'b0, -1, d, e);
        chk("stat_to1_err", e, 1);
        chk("stat_wr_cnt", wr_cnt, 3);
        chk("stat_rd_cnt", rd_cnt, 2);
        chk("stat_to_cnt", to_cnt, 1);
        for (int i = 1; i < 300; i++) begin
            run_op(1'b0, -1, d, e);
        end
        chk("stat_to_cnt_sat", to_cnt, 255);
        chk("stat_wr_cnt_hold", wr_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sd_access_sched
`default_nettype wire
